// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction memory and its program loader.
package imem_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Word returned for blocked or out-of-range fetches.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  // Number of loader bytes that make up one instruction word.
  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEFAULT_DATA_WIDTH);

  // Loader state machine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } load_state_e;

endpackage

// File: rtl/imem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module imem_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and one-cycle-latency read port.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a byte-serial big-endian program loader and a req/valid fetch port.
module instruction_memory_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DEPTH      = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(imem_pkg::NOP_WORD)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_end,
  output logic                  load_busy,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   load_words,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_err
);

  localparam int unsigned BPW    = (DATA_WIDTH == imem_pkg::DEFAULT_DATA_WIDTH) ?
                                   imem_pkg::BYTES_PER_WORD :
                                   imem_pkg::bytes_per_word(DATA_WIDTH);
  localparam int unsigned CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WCNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [WCNT_W-1:0] DEPTH_W   = WCNT_W'(DEPTH);

  imem_pkg::load_state_e state_q, state_n;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_n;
  logic [DATA_WIDTH-1:0] word_q, word_n;
  logic [WCNT_W-1:0]     word_cnt_n;
  logic                  err_n;
  logic                  sel_ram_q;

  logic [CNT_W-1:0]      eff_byte;
  logic [WCNT_W-1:0]     eff_words;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  byte_phase;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  accept_c;
  logic                  in_range_c;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  imem_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (fetch_addr),
    .rd_data (rd_data)
  );

  // Next-state, byte assembly, RAM write and fetch-accept decode.
  always_comb begin
    state_n    = state_q;
    byte_cnt_n = byte_cnt_q;
    word_n     = word_q;
    word_cnt_n = load_words;
    err_n      = load_err;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = word_q;

    // A restart makes this cycle's byte land as byte 0 of word 0.
    eff_byte   = load_start ? '0 : byte_cnt_q;
    eff_words  = load_start ? '0 : load_words;
    byte_phase = load_start || (state_q == imem_pkg::LOAD);

    // Merge the incoming byte MSB-first; a fresh word starts zeroed so a flush pads with zeros.
    asm_word = (eff_byte == '0) ? '0 : word_q;
    for (int unsigned b = 0; b < BPW; b++) begin
      if (eff_byte == CNT_W'(b)) begin
        asm_word[DATA_WIDTH-1-8*b -: 8] = load_byte;
      end
    end

    if (load_start) begin
      state_n    = imem_pkg::LOAD;
      byte_cnt_n = '0;
      word_cnt_n = '0;
      word_n     = '0;
      err_n      = 1'b0;
    end else if (state_q == imem_pkg::FLUSH) begin
      wr_en      = 1'b1;
      wr_addr    = ADDR_WIDTH'(load_words);
      wr_data    = word_q;
      word_cnt_n = load_words + 1'b1;
      byte_cnt_n = '0;
      state_n    = imem_pkg::IDLE;
    end

    if (byte_phase && load_valid) begin
      if (eff_words == DEPTH_W) begin
        err_n = 1'b1;
      end else if (eff_byte == LAST_BYTE) begin
        wr_en      = 1'b1;
        wr_addr    = ADDR_WIDTH'(eff_words);
        wr_data    = asm_word;
        word_n     = asm_word;
        word_cnt_n = eff_words + 1'b1;
        byte_cnt_n = '0;
      end else begin
        word_n     = asm_word;
        byte_cnt_n = eff_byte + 1'b1;
      end
    end

    // End is processed after any same-cycle byte.
    if (!load_start && (state_q == imem_pkg::LOAD) && load_end) begin
      state_n = (byte_cnt_n != '0) ? imem_pkg::FLUSH : imem_pkg::IDLE;
    end

    accept_c   = (state_q == imem_pkg::IDLE) && fetch_req && !load_start;
    in_range_c = ({1'b0, fetch_addr} < DEPTH_W);
    rd_en      = accept_c && in_range_c;
  end

  // State, loader registers and fetch response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= imem_pkg::IDLE;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      load_words  <= '0;
      load_err    <= 1'b0;
      load_busy   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      sel_ram_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      byte_cnt_q  <= byte_cnt_n;
      word_q      <= word_n;
      load_words  <= word_cnt_n;
      load_err    <= err_n;
      load_busy   <= (state_n != imem_pkg::IDLE);
      fetch_valid <= accept_c;
      fetch_err   <= accept_c && !in_range_c;
      sel_ram_q   <= rd_en;
    end
  end

  // Only an accepted in-range fetch exposes RAM data; everything else reads as NOP.
  assign fetch_data = sel_ram_q ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: default, DEPTH=4 and DEPTH=768 instances.
module tb_instruction_memory_loader;
  import imem_pkg::*;

  localparam logic [31:0] NOP = NOP_WORD;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_start, load_valid, load_end;
  logic [7:0] load_byte;
  logic       fetch_req;
  logic [9:0] fetch_addr;

  logic        d_busy, d_err, d_fv, d_fe;
  logic [10:0] d_words;
  logic [31:0] d_fd;
  logic        s_busy, s_err, s_fv, s_fe;
  logic [2:0]  s_words;
  logic [31:0] s_fd;
  logic        m_busy, m_err, m_fv, m_fe;
  logic [10:0] m_words;
  logic [31:0] m_fd;

  exp_t obs_d, obs_s, obs_m;
  assign obs_d = {d_fv, d_fe, d_fd};
  assign obs_s = {s_fv, s_fe, s_fd};
  assign obs_m = {m_fv, m_fe, m_fd};

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  instruction_memory_loader dut (
    .clock(clock), .reset_n(reset_n),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_end(load_end),
    .load_busy(d_busy), .load_err(d_err), .load_words(d_words),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(d_fv), .fetch_data(d_fd), .fetch_err(d_fe)
  );

  instruction_memory_loader #(.ADDR_WIDTH(2), .DEPTH(4)) dut_small (
    .clock(clock), .reset_n(reset_n),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_end(load_end),
    .load_busy(s_busy), .load_err(s_err), .load_words(s_words),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr[1:0]),
    .fetch_valid(s_fv), .fetch_data(s_fd), .fetch_err(s_fe)
  );

  instruction_memory_loader #(.ADDR_WIDTH(10), .DEPTH(768)) dut_mid (
    .clock(clock), .reset_n(reset_n),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_end(load_end),
    .load_busy(m_busy), .load_err(m_err), .load_words(m_words),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(m_fv), .fetch_data(m_fd), .fetch_err(m_fe)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_cycle(input logic start, input logic valid, input logic [7:0] b, input logic fin);
    load_start = start;
    load_valid = valid;
    load_byte  = b;
    load_end   = fin;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic fetch_cycle(input logic [9:0] addr, input exp_t e);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    sb_q.push_back(e);
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; load_end = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    #12;
    checks++; if (d_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", d_busy); else passed++;
    checks++; if (d_err !== 1'b0) $display("FAIL reset_err: got %b want 0", d_err); else passed++;
    checks++; if (d_words !== 11'd0) $display("FAIL reset_words: got %0d want 0", d_words); else passed++;
    checks++; if (obs_d !== exp_t'({1'b0, 1'b0, NOP}))
      $display("FAIL reset_fetch: got %h want %h", obs_d, exp_t'({1'b0, 1'b0, NOP})); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_fetch();
    logic [7:0] prog [8] = '{8'h54, 8'h10, 8'h00, 8'h00, 8'h58, 8'h00, 8'h00, 8'h00};
    exp_t e;
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (d_busy !== 1'b1) $display("FAIL start_busy: got %b want 1", d_busy); else passed++;
    for (int i = 0; i < 8; i++) begin
      load_cycle(1'b0, 1'b1, prog[i], 1'b0);
      if (i == 3) begin
        checks++; if (d_words !== 11'd1) $display("FAIL words_after_w0: got %0d want 1", d_words); else passed++;
      end
    end
    load_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (d_busy !== 1'b0) $display("FAIL end_busy: got %b want 0", d_busy); else passed++;
    checks++; if (d_words !== 11'd2) $display("FAIL load_words: got %0d want 2", d_words); else passed++;
    fetch_cycle(10'd0, {1'b1, 1'b0, 32'h5410_0000});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL fetch_w0: got %h want %h", obs_d, e); else passed++;
    fetch_cycle(10'd1, {1'b1, 1'b0, 32'h5800_0000});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL fetch_w1_b2b: got %h want %h", obs_d, e); else passed++;
    tick();
    checks++; if (obs_d !== exp_t'({1'b0, 1'b0, NOP}))
      $display("FAIL fetch_idle: got %h want %h", obs_d, exp_t'({1'b0, 1'b0, NOP})); else passed++;
  endtask

  task automatic test_flush();
    logic [7:0] prog [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    exp_t e;
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) load_cycle(1'b0, 1'b1, prog[i], 1'b0);
    load_cycle(1'b0, 1'b1, 8'h22, 1'b1);
    checks++; if (d_busy !== 1'b1) $display("FAIL flush_busy: got %b want 1", d_busy); else passed++;
    checks++; if (d_words !== 11'd1) $display("FAIL flush_words_pre: got %0d want 1", d_words); else passed++;
    tick();
    checks++; if (d_busy !== 1'b0) $display("FAIL flush_done_busy: got %b want 0", d_busy); else passed++;
    checks++; if (d_words !== 11'd2) $display("FAIL flush_words: got %0d want 2", d_words); else passed++;
    fetch_cycle(10'd0, {1'b1, 1'b0, 32'hAABB_CCDD});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL flush_fetch0: got %h want %h", obs_d, e); else passed++;
    fetch_cycle(10'd1, {1'b1, 1'b0, 32'h1122_0000});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL flush_pad: got %h want %h", obs_d, e); else passed++;
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [7:0] b0;
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      load_cycle(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 16) begin
        checks++; if (s_err !== 1'b0) $display("FAIL ovf_err_early: got %b want 0", s_err); else passed++;
      end
      if (i == 17) begin
        checks++; if (s_err !== 1'b1) $display("FAIL ovf_err_set: got %b want 1", s_err); else passed++;
      end
    end
    checks++; if (s_words !== 3'd4) $display("FAIL ovf_words: got %0d want 4", s_words); else passed++;
    load_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (s_err !== 1'b1) $display("FAIL ovf_err_sticky: got %b want 1", s_err); else passed++;
    for (int k = 0; k < 4; k++) begin
      b0 = 8'(4 * k + 1);
      fetch_cycle(10'(k), {1'b1, 1'b0, b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
      e = sb_q.pop_front();
      checks++; if (obs_s !== e) $display("FAIL ovf_ram%0d: got %h want %h", k, obs_s, e); else passed++;
    end
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (s_err !== 1'b0) $display("FAIL ovf_err_clear: got %b want 0", s_err); else passed++;
    load_cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_fetch_blocked();
    logic [7:0] prog [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_t blk = {1'b0, 1'b0, NOP};
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = 10'd0;
    sb_q.push_back(blk);
    load_start = 1'b1; tick(); load_start = 1'b0;
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL blk_start: got %h want %h", obs_d, e); else passed++;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(blk);
      load_valid = 1'b1; load_byte = prog[i]; tick(); load_valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (obs_d !== e) $display("FAIL blk_load%0d: got %h want %h", i, obs_d, e); else passed++;
    end
    sb_q.push_back(blk);
    load_end = 1'b1; tick(); load_end = 1'b0;
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL blk_end: got %h want %h", obs_d, e); else passed++;
    sb_q.push_back({1'b1, 1'b0, 32'h1234_5678});
    tick();
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL blk_first_idle: got %h want %h", obs_d, e); else passed++;
    fetch_req = 1'b0;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    fetch_cycle(10'd800, {1'b1, 1'b1, NOP});
    e = sb_q.pop_front();
    checks++; if (obs_m !== e) $display("FAIL oor_800: got %h want %h", obs_m, e); else passed++;
    checks++; if ({d_fv, d_fe} !== 2'b10) $display("FAIL inr_800_big: got %b want 10", {d_fv, d_fe}); else passed++;
    fetch_cycle(10'd768, {1'b1, 1'b1, NOP});
    e = sb_q.pop_front();
    checks++; if (obs_m !== e) $display("FAIL oor_768: got %h want %h", obs_m, e); else passed++;
    fetch_cycle(10'd0, {1'b1, 1'b0, 32'h1234_5678});
    e = sb_q.pop_front();
    checks++; if (obs_m !== e) $display("FAIL inr_0_mid: got %h want %h", obs_m, e); else passed++;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] pre [8] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01, 8'h23, 8'h45, 8'h67};
    logic [7:0] part [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] post [4] = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_t e;
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) load_cycle(1'b0, 1'b1, pre[i], 1'b0);
    load_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) load_cycle(1'b0, 1'b1, part[i], 1'b0);
    checks++; if ({d_busy, d_words} !== {1'b1, 11'd1})
      $display("FAIL pre_rst: got %b/%0d want 1/1", d_busy, d_words); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({d_busy, d_err, d_words} !== 13'd0)
      $display("FAIL async_rst_load: got %b/%b/%0d want 0/0/0", d_busy, d_err, d_words); else passed++;
    checks++; if (obs_d !== exp_t'({1'b0, 1'b0, NOP}))
      $display("FAIL async_rst_fetch: got %h want %h", obs_d, exp_t'({1'b0, 1'b0, NOP})); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    fetch_cycle(10'd0, {1'b1, 1'b0, 32'h1122_3344});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL rst_kept_w0: got %h want %h", obs_d, e); else passed++;
    fetch_cycle(10'd1, {1'b1, 1'b0, 32'h0123_4567});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL rst_untouched_w1: got %h want %h", obs_d, e); else passed++;
    load_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) load_cycle(1'b0, 1'b1, post[i], 1'b0);
    load_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (d_words !== 11'd1) $display("FAIL reload_words: got %0d want 1", d_words); else passed++;
    fetch_cycle(10'd0, {1'b1, 1'b0, 32'h9ABC_DEF0});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL reload_w0: got %h want %h", obs_d, e); else passed++;
    fetch_cycle(10'd1, {1'b1, 1'b0, 32'h0123_4567});
    e = sb_q.pop_front();
    checks++; if (obs_d !== e) $display("FAIL reload_w1: got %h want %h", obs_d, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_flush();
    test_overflow();
    test_fetch_blocked();
    test_out_of_range();
    test_reset_mid_load();
    checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
